// File: rtl/correlator_input_cond.sv
// rtl/correlator_input_cond.sv - probe input conditioning: sync, invert, glitch filter, edge stretch, edge counters
//
// Purpose
//   Conditions the two asynchronous probe pins feeding the correlator's
//   i_x/i_y sampling inputs. Each channel runs through:
//     sync chain -> optional invert -> glitch filter -> level or stretched edge pulse
//   and keeps a wrapping 8-bit count of qualifying edges.
//
// Ports
//   i_clk         clock
//   i_rst         asynchronous active-high reset, clears every flop
//   i_cg          clock-gate enable, all state holds while low
//   i_selftest    (only with CORRELATOR_INPUT_COND_SELFTEST_EN) LFSR replaces the pins
//   i_xPin/i_yPin raw asynchronous probes
//   i_invertX/Y   invert the channel after the synchronizer
//   i_filterLen   glitch-filter length in cycles (0 and 1 mean no filtering)
//   i_mode        0=level, 1=rise, 2=fall, 3=any edge (both channels)
//   i_stretchLen  edge-mode pulse length minus 1
//   i_clrCounts   synchronous clear of both edge counters
//   o_x/o_y       conditioned outputs (registered)
//   o_xEdges/Y    wrapping qualifying-edge counts
//
// Configuration
//   CORRELATOR_INPUT_COND_SELFTEST_EN: adds i_selftest and a 16-bit Fibonacci
//   LFSR (taps 16,14,13,11, seed 16'hACE1) as an alternative source.

`timescale 1ns/1ps

module correlator_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4,
    parameter int STRETCH_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cg,
`ifdef CORRELATOR_INPUT_COND_SELFTEST_EN
    input  logic                 i_selftest,
`endif
    input  logic                 i_xPin,
    input  logic                 i_yPin,
    input  logic                 i_invertX,
    input  logic                 i_invertY,
    input  logic [FILTER_W-1:0]  i_filterLen,
    input  logic [1:0]           i_mode,
    input  logic [STRETCH_W-1:0] i_stretchLen,
    input  logic                 i_clrCounts,
    output logic                 o_x,
    output logic                 o_y,
    output logic [7:0]           o_xEdges,
    output logic [7:0]           o_yEdges
);

    localparam logic [1:0] MODE_LEVEL = 2'd0;
    localparam logic [1:0] MODE_RISE  = 2'd1;
    localparam logic [1:0] MODE_FALL  = 2'd2;
    localparam logic [1:0] MODE_ANY   = 2'd3;

    // Channel 0 is X, channel 1 is Y.
    logic [1:0] pin_w;
    logic [1:0] invert_w;
    logic [1:0] out_w;
    logic [7:0] edges_w [2];

    assign pin_w    = {i_yPin, i_xPin};
    assign invert_w = {i_invertY, i_invertX};

    // Mismatch count at which the filter flips. L = max(i_filterLen, 1), so
    // lengths 0 and 1 both flip on the first mismatching cycle. A >= compare
    // (rather than ==) lets a shortened length take effect immediately even
    // if the running count is already past the new limit.
    logic [FILTER_W-1:0] filt_limit_w;
    assign filt_limit_w = (i_filterLen == '0) ? '0 : (i_filterLen - FILTER_W'(1));

`ifdef CORRELATOR_INPUT_COND_SELFTEST_EN
    // Self-test source: Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    // Y sees the X bit one cycle late so the two channels are decorrelated
    // by a known lag.
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        lfsr_y_q;
    logic [1:0]  lfsr_bit_w;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_q   <= 16'hACE1;
            lfsr_y_q <= 1'b0;
        end else if (i_cg) begin
            lfsr_q   <= lfsr_d;
            lfsr_y_q <= lfsr_q[0];
        end
    end

    assign lfsr_bit_w = {lfsr_y_q, lfsr_q[0]};
`endif

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   src_w;
        logic                   s_w;

        logic                   filt_q, filt_d;
        logic [FILTER_W-1:0]    cnt_q, cnt_d;
        logic                   prev_q;
        logic [STRETCH_W-1:0]   str_q, str_d;
        logic                   out_q, out_d;
        logic [7:0]             edges_q, edges_d;

        logic                   rise_w;
        logic                   fall_w;
        logic                   qual_w;

`ifdef CORRELATOR_INPUT_COND_SELFTEST_EN
        assign src_w = i_selftest ? lfsr_bit_w[ch] : sync_q[SYNC_STAGES-1];
`else
        assign src_w = sync_q[SYNC_STAGES-1];
`endif
        assign s_w = src_w ^ invert_w[ch];

        always_comb begin
            rise_w = filt_q & ~prev_q;
            fall_w = ~filt_q & prev_q;

            case (i_mode)
                MODE_RISE: qual_w = rise_w;
                MODE_FALL: qual_w = fall_w;
                MODE_ANY:  qual_w = rise_w | fall_w;
                default:   qual_w = 1'b0;
            endcase

            // Glitch filter: filt only follows s after L consecutive
            // mismatching cycles; any agreement restarts the count.
            filt_d = filt_q;
            cnt_d  = cnt_q;
            if (s_w == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q >= filt_limit_w) begin
                filt_d = ~filt_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + FILTER_W'(1);
            end

            // Output stage. In level mode the stretch counter is left alone
            // so a later switch back to an edge mode resumes where it was.
            str_d = str_q;
            out_d = out_q;
            if (i_mode == MODE_LEVEL) begin
                out_d = filt_q;
            end else if (qual_w) begin
                // Retrigger reloads, so overlapping pulses merge.
                str_d = i_stretchLen;
                out_d = 1'b1;
            end else if (str_q != '0) begin
                str_d = str_q - STRETCH_W'(1);
                out_d = 1'b1;
            end else begin
                out_d = 1'b0;
            end

            // Clear wins over a coincident edge.
            if (i_clrCounts) begin
                edges_d = '0;
            end else if (qual_w) begin
                edges_d = edges_q + 8'd1;
            end else begin
                edges_d = edges_q;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                sync_q  <= '0;
                filt_q  <= 1'b0;
                cnt_q   <= '0;
                prev_q  <= 1'b0;
                str_q   <= '0;
                out_q   <= 1'b0;
                edges_q <= '0;
            end else if (i_cg) begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_w[ch]};
                filt_q  <= filt_d;
                cnt_q   <= cnt_d;
                prev_q  <= filt_q;
                str_q   <= str_d;
                out_q   <= out_d;
                edges_q <= edges_d;
            end
        end

        assign out_w[ch]   = out_q;
        assign edges_w[ch] = edges_q;
    end

    assign o_x      = out_w[0];
    assign o_y      = out_w[1];
    assign o_xEdges = edges_w[0];
    assign o_yEdges = edges_w[1];

endmodule

// File: tb/tb_correlator_input_cond.sv
// tb/tb_correlator_input_cond.sv - self-checking bench for correlator_input_cond

`timescale 1ns/1ps

module tb_correlator_input_cond;

    localparam int SYNC = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       cg   = 1'b1;
    logic       xpin = 1'b0;
    logic       ypin = 1'b0;
    logic       invx = 1'b0;
    logic       invy = 1'b0;
    logic       clr  = 1'b0;
    logic [3:0] flen = 4'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] slen = 8'd0;

    logic       o_x;
    logic       o_y;
    logic [7:0] xe;
    logic [7:0] ye;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    correlator_input_cond #(
        .SYNC_STAGES (SYNC),
        .FILTER_W    (4),
        .STRETCH_W   (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cg         (cg),
`ifdef CORRELATOR_INPUT_COND_SELFTEST_EN
        .i_selftest   (1'b0),
`endif
        .i_xPin       (xpin),
        .i_yPin       (ypin),
        .i_invertX    (invx),
        .i_invertY    (invy),
        .i_filterLen  (flen),
        .i_mode       (mode),
        .i_stretchLen (slen),
        .i_clrCounts  (clr),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_xEdges     (xe),
        .o_yEdges     (ye)
    );

    // Reference model: pins delayed by SYNC cycles, filter as "L consecutive
    // disagreeing cycles flip the level", edge output as "time since last
    // qualifying edge <= stretchLen", counters as edge totals mod 256.
    bit hist [2][64];
    bit m_filt [2];
    bit m_prev [2];
    bit m_out  [2];
    int m_run  [2];
    int m_age  [2];
    int m_cnt  [2];
    int mc;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 64; k++) hist[c][k] = 1'b0;
            m_filt[c] = 1'b0;
            m_prev[c] = 1'b0;
            m_out[c]  = 1'b0;
            m_run[c]  = 0;
            m_age[c]  = 1000;
            m_cnt[c]  = 0;
        end
        mc = 0;
    endtask

    task automatic model_edge();
        if (rst || !cg) return;
        for (int c = 0; c < 2; c++) begin
            bit pin, inv, s, f0, p0, qual;
            int len;
            pin  = (c == 0) ? xpin : ypin;
            inv  = (c == 0) ? invx : invy;
            s    = ((mc >= SYNC) ? hist[c][(mc - SYNC) % 64] : 1'b0) ^ inv;
            hist[c][mc % 64] = pin;
            len  = (flen == 0) ? 1 : int'(flen);
            f0   = m_filt[c];
            p0   = m_prev[c];
            case (mode)
                2'd1:    qual = f0 && !p0;
                2'd2:    qual = !f0 && p0;
                2'd3:    qual = f0 != p0;
                default: qual = 1'b0;
            endcase
            if (s != f0) begin
                m_run[c]++;
                if (m_run[c] >= len) begin
                    m_filt[c] = !f0;
                    m_run[c]  = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_prev[c] = f0;
            if (mode == 2'd0) begin
                m_out[c] = f0;
            end else begin
                if (qual) m_age[c] = 0;
                else if (m_age[c] < 1000) m_age[c]++;
                m_out[c] = (m_age[c] <= int'(slen));
            end
            if (clr) m_cnt[c] = 0;
            else if (qual) m_cnt[c] = (m_cnt[c] + 1) % 256;
        end
        mc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        xpin = 0; ypin = 0; mode = 0; flen = 0; invx = 0; invy = 0;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({o_x, o_y, xe, ye} !== 18'd0) begin
            errors++;
            $display("FAIL reset_async: got %0h expected 0", {o_x, o_y, xe, ye});
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if ({o_x, o_y, xe, ye} !== 18'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %0h expected 0", k, {o_x, o_y, xe, ye});
            end
        end
    endtask

    task automatic test_level_latency();
        mode = 0; flen = 0; xpin = 0;
        do_reset();
        repeat (3) tick();
        xpin = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (o_x !== (k >= 4)) begin
                errors++;
                $display("FAIL level_latency cycle %0d: got %0b expected %0b", k, o_x, (k >= 4));
            end
        end
    endtask

    task automatic test_filter();
        mode = 0; flen = 4; xpin = 0;
        do_reset();
        repeat (5) tick();
        xpin = 1;
        repeat (3) tick();
        xpin = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (o_x !== 1'b0) begin
                errors++;
                $display("FAIL filter_short cycle %0d: got %0b expected 0", k, o_x);
            end
        end
        xpin = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (o_x !== (k >= 7 && k <= 10)) begin
                errors++;
                $display("FAIL filter_pass cycle %0d: got %0b expected %0b", k, o_x, (k >= 7 && k <= 10));
            end
            if (k == 4) xpin = 0;
        end
        flen = 0;
    endtask

    task automatic test_stretch();
        int high, rises;
        logic prevo;
        mode = 1; slen = 9; flen = 0; xpin = 0;
        do_reset();
        repeat (3) tick();
        xpin = 1;
        high = 0; rises = 0; prevo = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (o_x) high++;
            if (o_x && !prevo) rises++;
            prevo = o_x;
            if (k == 3 || k == 4 || k == 13 || k == 14) begin
                checks++;
                if (o_x !== (k == 4 || k == 13)) begin
                    errors++;
                    $display("FAIL stretch_edge cycle %0d: got %0b expected %0b", k, o_x, (k == 4 || k == 13));
                end
            end
        end
        checks++;
        if (high != 10 || rises != 1 || xe !== 8'd1) begin
            errors++;
            $display("FAIL stretch_single: got high=%0d pulses=%0d edges=%0d expected 10 1 1", high, rises, xe);
        end
        xpin = 0;
        repeat (10) tick();
        checks++;
        if (o_x !== 1'b0 || xe !== 8'd1) begin
            errors++;
            $display("FAIL stretch_fall_ignored: got o_x=%0b edges=%0d expected 0 1", o_x, xe);
        end
        clr = 1;
        tick();
        clr = 0;
        xpin = 1;
        high = 0; rises = 0; prevo = 0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (o_x) high++;
            if (o_x && !prevo) rises++;
            prevo = o_x;
            if (k == 18 || k == 19) begin
                checks++;
                if (o_x !== (k == 18)) begin
                    errors++;
                    $display("FAIL stretch_merge_end cycle %0d: got %0b expected %0b", k, o_x, (k == 18));
                end
            end
            if (k == 2) xpin = 0;
            if (k == 5) xpin = 1;
        end
        checks++;
        if (high != 15 || rises != 1 || xe !== 8'd2) begin
            errors++;
            $display("FAIL stretch_merge: got high=%0d pulses=%0d edges=%0d expected 15 1 2", high, rises, xe);
        end
    endtask

    task automatic test_any_edge_wrap();
        mode = 3; slen = 0; flen = 0; invy = 1; ypin = 0; xpin = 0;
        do_reset();
        repeat (8) tick();
        checks++;
        if (ye !== 8'd1) begin
            errors++;
            $display("FAIL wrap_powerup_edge: got %0d expected 1", ye);
        end
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 300; i++) begin
            ypin = ~ypin;
            tick();
            tick();
        end
        repeat (8) tick();
        checks++;
        if (ye !== 8'd44 || xe !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count: got y=%0d x=%0d expected 44 0", ye, xe);
        end
        ypin = ~ypin;
        repeat (3) tick();
        checks++;
        if (ye !== 8'd44) begin
            errors++;
            $display("FAIL clr_pre_edge: got %0d expected 44", ye);
        end
        clr = 1;
        tick();
        clr = 0;
        checks++;
        if (ye !== 8'd0) begin
            errors++;
            $display("FAIL clr_on_edge: got %0d expected 0", ye);
        end
        repeat (5) tick();
        checks++;
        if (ye !== 8'd0) begin
            errors++;
            $display("FAIL clr_after_edge: got %0d expected 0", ye);
        end
        invy = 0;
    endtask

    task automatic test_cg_freeze();
        int high;
        mode = 1; slen = 9; flen = 0; xpin = 0; ypin = 0;
        do_reset();
        repeat (3) tick();
        xpin = 1;
        repeat (6) tick();
        checks++;
        if (o_x !== 1'b1 || xe !== 8'd1) begin
            errors++;
            $display("FAIL freeze_setup: got o_x=%0b edges=%0d expected 1 1", o_x, xe);
        end
        cg = 0;
        for (int k = 0; k < 20; k++) begin
            xpin = 1'($urandom);
            ypin = 1'($urandom);
            clr  = (k == 10);
            tick();
            checks++;
            if ({o_x, o_y, xe, ye} !== {1'b1, 1'b0, 8'd1, 8'd0}) begin
                errors++;
                $display("FAIL freeze_hold cycle %0d: got %0h expected %0h", k, {o_x, o_y, xe, ye}, {1'b1, 1'b0, 8'd1, 8'd0});
            end
        end
        clr = 0; xpin = 1; ypin = 0;
        cg = 1;
        high = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_x) high++;
        end
        checks++;
        if (high != 7 || xe !== 8'd1) begin
            errors++;
            $display("FAIL freeze_resume: got high=%0d edges=%0d expected 7 1", high, xe);
        end
    endtask

    task automatic test_async_reset();
        mode = 1; slen = 9; flen = 0; xpin = 0; ypin = 0;
        do_reset();
        repeat (3) tick();
        xpin = 1; ypin = 1;
        repeat (6) tick();
        checks++;
        if ({o_x, o_y, xe, ye} !== {1'b1, 1'b1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL areset_setup: got %0h expected %0h", {o_x, o_y, xe, ye}, {1'b1, 1'b1, 8'd1, 8'd1});
        end
        #2;
        rst = 1; xpin = 0; ypin = 0;
        model_reset();
        #1;
        checks++;
        if ({o_x, o_y, xe, ye} !== 18'd0) begin
            errors++;
            $display("FAIL areset_immediate: got %0h expected 0", {o_x, o_y, xe, ye});
        end
        tick();
        rst = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({o_x, o_y, xe, ye} !== 18'd0) begin
                errors++;
                $display("FAIL areset_restart cycle %0d: got %0h expected 0", k, {o_x, o_y, xe, ye});
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] exp_v;
        for (int seg = 0; seg < 8; seg++) begin
            mode = 2'($urandom_range(0, 3));
            flen = 4'($urandom_range(0, 5));
            slen = 8'($urandom_range(0, 6));
            invx = 1'($urandom);
            invy = 1'($urandom);
            xpin = 0; ypin = 0; cg = 1; clr = 0;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 3) == 0) xpin = ~xpin;
                if ($urandom_range(0, 3) == 0) ypin = ~ypin;
                cg  = ($urandom_range(0, 9) != 0);
                clr = ($urandom_range(0, 49) == 0);
                tick();
                exp_v = {m_out[0], m_out[1], 8'(m_cnt[0]), 8'(m_cnt[1])};
                checks++;
                if ({o_x, o_y, xe, ye} !== exp_v) begin
                    errors++;
                    $display("FAIL random seg %0d cycle %0d mode %0d: got %0h expected %0h", seg, c, mode, {o_x, o_y, xe, ye}, exp_v);
                end
            end
        end
        cg = 1; clr = 0; invx = 0; invy = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_level_latency();
        test_filter();
        test_stretch();
        test_any_edge_wrap();
        test_cg_freeze();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
